// File: rtl/control_sequencer_if.sv
// Bundles the control sequencer's memory, control and timing signals.
// The master side is the control logic, which drives the memory word and
// the sc_clr/halt/start controls. The slave side is the sequencer, which
// returns the timing, instruction-register and status outputs.
interface control_sequencer_if;
  logic [15:0] mem_data;
  logic        sc_clr;
  logic        halt;
  logic        start;
  logic [15:0] t;
  logic [3:0]  sc;
  logic [15:0] ir;
  logic [2:0]  instruction;
  logic        i_bit;
  logic        running;
  logic [15:0] instr_count;

  modport master (
    output mem_data, sc_clr, halt, start,
    input  t, sc, ir, instruction, i_bit, running, instr_count
  );

  modport slave (
    input  mem_data, sc_clr, halt, start,
    output t, sc, ir, instruction, i_bit, running, instr_count
  );
endinterface

// File: rtl/control_sequencer.sv
// Timing and fetch sequencer for the basic computer's control unit.
// Owns the sequence counter (SC), the instruction register (IR), the
// run/halt flip-flop and a completed-instruction counter. It decodes SC
// into the one-hot timing signals T0..T15 and exposes the IR fields that
// the opcode decoder consumes.
module control_sequencer (
  input  logic                clk,
  input  logic                reset,
  control_sequencer_if.slave  bus
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  logic [0:0]  state;
  logic [3:0]  sc_q;
  logic [15:0] ir_q;
  logic [15:0] count_q;
  logic [15:0] t_dec;

  // Run/halt flip-flop, sequence counter and completed-instruction counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, whatever the statement order.
  // NOTE: every register here is an ordinary flop, not a memory array, so
  // all of them take the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_RUN;
      sc_q    <= 4'd0;
      count_q <= 16'd0;
    end else if (state == ST_RUN) begin
      if (bus.halt) begin
        // HLT completes the current instruction and parks SC at 0.
        state   <= ST_HALTED;
        sc_q    <= 4'd0;
        count_q <= count_q + 16'd1;
      end else if (bus.sc_clr) begin
        sc_q    <= 4'd0;
        count_q <= count_q + 16'd1;
      end else begin
        // Natural 15 -> 0 wrap is not an instruction completion.
        sc_q <= sc_q + 4'd1;
      end
    end else if (bus.start) begin
      // Resume from T0. SC was already cleared on entry to HALTED.
      state <= ST_RUN;
    end
  end

  // Instruction register: loaded from memory on the edge that ends T1.
  // The load also happens when halt or sc_clr arrive on that same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q <= 16'h0000;
    end else if (state == ST_RUN && sc_q == 4'd1) begin
      ir_q <= bus.mem_data;
    end
  end

  // One-hot timing decode. All timing signals are off while halted.
  // NOTE: assigning t_dec a default first keeps this block purely
  // combinational; an unassigned path would infer a latch.
  always_comb begin
    t_dec = 16'h0000;
    if (state == ST_RUN) begin
      t_dec = 16'h0001 << sc_q;
    end
  end

  assign bus.t           = t_dec;
  assign bus.sc          = sc_q;
  assign bus.ir          = ir_q;
  assign bus.instruction = ir_q[14:12];
  assign bus.i_bit       = ir_q[15];
  assign bus.running     = (state == ST_RUN);
  assign bus.instr_count = count_q;

endmodule
